// File: rtl/prng_arbiter.sv
// Round-robin arbiter that hands out one fresh word of a shared XOR PRNG per grant.
// Owns the generator's step/load controls and discards WARMUP words after reset or reseed.
module prng_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int WARMUP  = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [WIDTH-1:0]   rnd_o,
  output logic               ready_o,
  input  logic               seed_load_i,
  input  logic [WIDTH-1:0]   seed_i,
  input  logic [WIDTH-1:0]   prng_data_i,
  output logic               prng_step_o,
  output logic               prng_load_o,
  output logic [WIDTH-1:0]   prng_seed_o
);

  localparam int PW = $clog2(NUM_REQ);
  localparam logic [15:0] WARM_CNT = 16'(WARMUP);

  typedef enum logic [1:0] {S_WARMUP, S_SERVE, S_LOAD} state_e;

  // With no warm-up configured, both reset and reseed land directly in SERVE.
  localparam state_e START_STATE = (WARMUP == 0) ? S_SERVE : S_WARMUP;

  state_e             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [PW-1:0]      rr_q, rr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [WIDTH-1:0]   rnd_q, rnd_d;
  logic [WIDTH-1:0]   seed_q, seed_d;
  logic               load_q, load_d;

  logic [NUM_REQ-1:0] elig;
  logic               found;
  logic [PW-1:0]      win;
  logic [PW:0]        sum;
  logic [PW-1:0]      idx;
  logic               step;

  // The requester currently holding its grant is masked so every word is used once.
  always_comb begin
    elig  = req_i & ~gnt_q;
    found = 1'b0;
    win   = '0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_REQ)) begin
        sum = sum - (PW+1)'(NUM_REQ);
      end
      idx = sum[PW-1:0];
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    gnt_d   = '0;
    rnd_d   = rnd_q;
    seed_d  = seed_q;
    load_d  = 1'b0;
    step    = 1'b0;
    if (seed_load_i) begin
      seed_d  = seed_i;
      load_d  = 1'b1;
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_WARMUP: begin
          step  = 1'b1;
          cnt_d = cnt_q - 16'd1;
          if (cnt_q <= 16'd1) begin
            state_d = S_SERVE;
          end
        end
        S_LOAD: begin
          cnt_d   = WARM_CNT;
          state_d = START_STATE;
        end
        S_SERVE: begin
          if (found) begin
            step       = 1'b1;
            gnt_d[win] = 1'b1;
            rnd_d      = prng_data_i;
            rr_d       = (win == PW'(NUM_REQ-1)) ? '0 : win + 1'b1;
          end
        end
        default: state_d = START_STATE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= START_STATE;
      cnt_q   <= WARM_CNT;
      rr_q    <= '0;
      gnt_q   <= '0;
      rnd_q   <= '0;
      seed_q  <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      rnd_q   <= rnd_d;
      seed_q  <= seed_d;
      load_q  <= load_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign rnd_o       = rnd_q;
  assign prng_load_o = load_q;
  assign prng_seed_o = seed_q;
  assign ready_o     = rst_ni && (state_q == S_SERVE);
  assign prng_step_o = rst_ni && step;

endmodule

// File: tb/tb_prng_arbiter.sv
// Bench for prng_arbiter: a xorshift32 generator plus a word-index reference model.
module tb_prng_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int WU = 8;
  localparam logic [31:0] SEED0 = 32'h1234_5678;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [N-1:0]  req_i = '0;
  logic [N-1:0]  gnt_o;
  logic [W-1:0]  rnd_o;
  logic          ready_o;
  logic          seed_load_i = 1'b0;
  logic [W-1:0]  seed_i = '0;
  logic [W-1:0]  prng_data_i;
  logic          prng_step_o;
  logic          prng_load_o;
  logic [W-1:0]  prng_seed_o;

  int n_checks = 0;
  int n_fail = 0;

  prng_arbiter #(.NUM_REQ(N), .WIDTH(W), .WARMUP(WU)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .rnd_o(rnd_o),
    .ready_o(ready_o), .seed_load_i(seed_load_i), .seed_i(seed_i),
    .prng_data_i(prng_data_i), .prng_step_o(prng_step_o), .prng_load_o(prng_load_o),
    .prng_seed_o(prng_seed_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] v;
    v = x;
    v = v ^ (v << 13);
    v = v ^ (v >> 17);
    v = v ^ (v << 5);
    return v;
  endfunction

  function automatic logic [31:0] word_n(input logic [31:0] s, input int n);
    logic [31:0] v;
    v = s;
    for (int i = 0; i < n; i++) v = xs(v);
    return v;
  endfunction

  function automatic logic [N-1:0] gvec(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  // The generator itself; its clock and reset are wired directly.
  logic [31:0] gen_q;
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)          gen_q <= SEED0;
    else if (prng_load_o) gen_q <= prng_seed_o;
    else if (prng_step_o) gen_q <= xs(gen_q);
  end
  assign prng_data_i = gen_q;

  // Reference model: phase 0=warm-up, 1=serve, 2=load; words tracked as (seed, index).
  int          m_phase, m_cnt, m_rr, m_gnt, m_widx, m_step_exp;
  logic [31:0] m_rnd, m_seed, m_seed_out;
  logic        m_load;
  logic        obs_step;

  task automatic model_reset();
    m_phase = (WU == 0) ? 1 : 0;
    m_cnt = WU; m_rr = 0; m_gnt = -1; m_widx = 0; m_step_exp = 0;
    m_rnd = '0; m_seed = SEED0; m_seed_out = '0; m_load = 1'b0;
  endtask

  // Advance one clock: sample the combinational step, predict the edge, then wait past it.
  task automatic cyc();
    logic        was_load;
    logic [31:0] lseed;
    int          step, win, idx, gnew;
    #1;
    obs_step = prng_step_o;
    was_load = m_load;
    lseed = m_seed_out;
    step = 0; gnew = -1; m_load = 1'b0;
    if (seed_load_i) begin
      m_seed_out = seed_i; m_load = 1'b1; m_phase = 2;
    end else if (m_phase == 0) begin
      step = 1; m_cnt = m_cnt - 1;
      if (m_cnt == 0) m_phase = 1;
    end else if (m_phase == 2) begin
      m_cnt = WU; m_phase = (WU == 0) ? 1 : 0;
    end else begin
      win = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (win < 0 && req_i[idx] && idx != m_gnt) win = idx;
      end
      if (win >= 0) begin
        step = 1; gnew = win; m_rnd = word_n(m_seed, m_widx); m_rr = (win + 1) % N;
      end
    end
    if (was_load) begin m_seed = lseed; m_widx = 0; end
    else if (step != 0) m_widx++;
    m_gnt = gnew;
    m_step_exp = step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; req_i = '0; seed_load_i = 1'b0; seed_i = '0;
    model_reset();
    #3;
    n_checks++; if (gnt_o !== '0) begin n_fail++; $display("FAIL rst_gnt: got %b want 0", gnt_o); end
    n_checks++; if (rnd_o !== '0) begin n_fail++; $display("FAIL rst_rnd: got %h want 0", rnd_o); end
    n_checks++; if (prng_load_o !== 1'b0) begin n_fail++; $display("FAIL rst_load: got %b want 0", prng_load_o); end
    n_checks++; if (prng_seed_o !== '0) begin n_fail++; $display("FAIL rst_seed: got %h want 0", prng_seed_o); end
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", ready_o); end
    n_checks++; if (prng_step_o !== 1'b0) begin n_fail++; $display("FAIL rst_step: got %b want 0", prng_step_o); end
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    for (int i = 1; i <= WU; i++) begin
      cyc();
      n_checks++; if (obs_step !== 1'b1) begin n_fail++; $display("FAIL warm_step c%0d: got %b want 1", i, obs_step); end
      n_checks++; if (ready_o !== (i == WU)) begin n_fail++; $display("FAIL warm_ready c%0d: got %b want %b", i, ready_o, i == WU); end
      n_checks++; if (gnt_o !== '0) begin n_fail++; $display("FAIL warm_gnt c%0d: got %b want 0", i, gnt_o); end
    end
    cyc();
    n_checks++; if (obs_step !== 1'b0) begin n_fail++; $display("FAIL idle_step: got %b want 0", obs_step); end
    n_checks++; if (gen_q !== word_n(SEED0, WU)) begin n_fail++; $display("FAIL warm_words: got %h want %h", gen_q, word_n(SEED0, WU)); end
  endtask

  task automatic test_round_robin();
    req_i = 4'b1111;
    for (int i = 0; i < N; i++) begin
      cyc();
      n_checks++; if (gnt_o !== gvec(i)) begin n_fail++; $display("FAIL rr_order %0d: got %b want %b", i, gnt_o, gvec(i)); end
      n_checks++; if (rnd_o !== word_n(SEED0, WU + i)) begin n_fail++; $display("FAIL rr_word %0d: got %h want %h", i, rnd_o, word_n(SEED0, WU + i)); end
      req_i = req_i & ~gnt_o;
    end
    cyc();
    n_checks++; if (gnt_o !== '0) begin n_fail++; $display("FAIL rr_idle: got %b want 0", gnt_o); end
  endtask

  task automatic test_wrap();
    logic [N-1:0] exp_seq [5];
    logic [N-1:0] req_seq [5];
    req_seq = '{4'b0100, 4'b1001, 4'b0001, 4'b0000, 4'b0100};
    exp_seq = '{4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0100};
    for (int i = 0; i < 5; i++) begin
      req_i = req_seq[i];
      cyc();
      n_checks++; if (gnt_o !== exp_seq[i]) begin n_fail++; $display("FAIL wrap_gnt %0d: got %b want %b", i, gnt_o, exp_seq[i]); end
      if (m_gnt >= 0) begin
        n_checks++; if (rnd_o !== m_rnd) begin n_fail++; $display("FAIL wrap_word %0d: got %h want %h", i, rnd_o, m_rnd); end
      end
    end
    req_i = '0;
    cyc();
  endtask

  task automatic test_hog();
    logic [31:0] seen [$];
    int grants;
    grants = 0;
    req_i = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_checks++; if (gnt_o !== ((i % 2 == 0) ? 4'b0010 : 4'b0000)) begin n_fail++; $display("FAIL hog_gnt c%0d: got %b", i, gnt_o); end
      if (gnt_o == 4'b0010) begin
        grants++;
        n_checks++; if (rnd_o !== m_rnd) begin n_fail++; $display("FAIL hog_word c%0d: got %h want %h", i, rnd_o, m_rnd); end
        foreach (seen[j]) begin
          n_checks++; if (seen[j] === rnd_o) begin n_fail++; $display("FAIL hog_repeat c%0d: word %h seen before", i, rnd_o); end
        end
        seen.push_back(rnd_o);
      end
    end
    n_checks++; if (grants !== 5) begin n_fail++; $display("FAIL hog_count: got %0d want 5", grants); end
    req_i = '0;
    cyc();
  endtask

  task automatic test_reseed();
    req_i = 4'b0010; seed_load_i = 1'b1; seed_i = 32'hDEADBEEF;
    cyc();
    n_checks++; if (obs_step !== 1'b0) begin n_fail++; $display("FAIL rs_step: got %b want 0", obs_step); end
    n_checks++; if (gnt_o !== '0) begin n_fail++; $display("FAIL rs_gnt: got %b want 0", gnt_o); end
    n_checks++; if (prng_load_o !== 1'b1) begin n_fail++; $display("FAIL rs_load: got %b want 1", prng_load_o); end
    n_checks++; if (prng_seed_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rs_seed: got %h want deadbeef", prng_seed_o); end
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL rs_ready: got %b want 0", ready_o); end
    seed_load_i = 1'b0; seed_i = $urandom;
    cyc();
    n_checks++; if (obs_step !== 1'b0) begin n_fail++; $display("FAIL rs_load_step: got %b want 0", obs_step); end
    n_checks++; if (gen_q !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rs_gen: got %h want deadbeef", gen_q); end
    for (int i = 0; i < WU; i++) begin
      cyc();
      n_checks++; if (obs_step !== 1'b1) begin n_fail++; $display("FAIL rs_warm_step c%0d: got %b want 1", i, obs_step); end
      n_checks++; if (gnt_o !== '0) begin n_fail++; $display("FAIL rs_warm_gnt c%0d: got %b want 0", i, gnt_o); end
    end
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rs_ready_back: got %b want 1", ready_o); end
    cyc();
    n_checks++; if (gnt_o !== 4'b0010) begin n_fail++; $display("FAIL rs_grant: got %b want 0010", gnt_o); end
    n_checks++; if (rnd_o !== word_n(32'hDEADBEEF, WU)) begin n_fail++; $display("FAIL rs_word: got %h want %h", rnd_o, word_n(32'hDEADBEEF, WU)); end
    req_i = '0;
    cyc();
  endtask

  task automatic test_reset_mid_grant();
    req_i = 4'b0001;
    cyc();
    n_checks++; if (gnt_o !== 4'b0001) begin n_fail++; $display("FAIL mid_pre_gnt: got %b want 0001", gnt_o); end
    rst_ni = 1'b0;
    model_reset();
    #1;
    n_checks++; if (gnt_o !== '0) begin n_fail++; $display("FAIL mid_gnt: got %b want 0", gnt_o); end
    n_checks++; if (rnd_o !== '0) begin n_fail++; $display("FAIL mid_rnd: got %h want 0", rnd_o); end
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got %b want 0", ready_o); end
    req_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    for (int i = 1; i <= WU; i++) begin
      cyc();
      n_checks++; if (obs_step !== 1'b1) begin n_fail++; $display("FAIL mid_warm_step c%0d: got %b want 1", i, obs_step); end
      n_checks++; if (ready_o !== (i == WU)) begin n_fail++; $display("FAIL mid_warm_ready c%0d: got %b want %b", i, ready_o, i == WU); end
    end
    n_checks++; if (gen_q !== word_n(SEED0, WU)) begin n_fail++; $display("FAIL mid_words: got %h want %h", gen_q, word_n(SEED0, WU)); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) if (!req_i[i] && ($urandom % 4 == 0)) req_i[i] = 1'b1;
      seed_load_i = ($urandom % 50 == 0);
      seed_i = $urandom | 32'h1;
      cyc();
      n_checks++; if (obs_step !== m_step_exp[0]) begin n_fail++; $display("FAIL rnd_step c%0d: got %b want %0d", c, obs_step, m_step_exp); end
      n_checks++; if (gnt_o !== gvec(m_gnt)) begin n_fail++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, gnt_o, gvec(m_gnt)); end
      if (m_gnt >= 0) begin
        n_checks++; if (rnd_o !== m_rnd) begin n_fail++; $display("FAIL rnd_word c%0d: got %h want %h", c, rnd_o, m_rnd); end
      end
      n_checks++; if (ready_o !== (m_phase == 1)) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", c, ready_o, m_phase == 1); end
      n_checks++; if (prng_load_o !== m_load) begin n_fail++; $display("FAIL rnd_load c%0d: got %b want %b", c, prng_load_o, m_load); end
      n_checks++; if (prng_seed_o !== m_seed_out) begin n_fail++; $display("FAIL rnd_seed c%0d: got %h want %h", c, prng_seed_o, m_seed_out); end
      // Occasionally a requester keeps req_i high past its grant, which counts as a new request.
      if ($urandom % 8 != 0) req_i = req_i & ~gnt_o;
    end
    req_i = '0; seed_load_i = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_wrap();
    test_hog();
    test_reseed();
    test_reset_mid_grant();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/prng_arbiter.md
# prng_arbiter

Round-robin scheduler that shares one XOR PRNG instance among several consumers in the WalkSAT datapath, such as clause picker, variable picker and noise comparator. After reset or reseed it runs a warm-up phase that discards the first WARMUP generator words. It then hands out one fresh, never-repeated word per grant, at up to one grant per cycle. It owns the generator's step and seed-load controls; the generator's own clock and reset are wired directly.

## Interface
- NUM_REQ, 4: number of requesters, 2..16.
- WIDTH, 32: PRNG word width.
- WARMUP, 16: words discarded after reset or reseed, 0..65535.
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- req_i  in  NUM_REQ  level request per consumer; held until granted.
- gnt_o  out  NUM_REQ  registered one-hot grant pulse, one cycle.
- rnd_o  out  WIDTH  registered word; valid only while gnt_o != 0.
- ready_o  out  1  high in SERVE state.
- seed_load_i  in  1  single-cycle reseed request.
- seed_i  in  WIDTH  new seed, sampled when seed_load_i=1.
- prng_data_i  in  WIDTH  current generator output.
- prng_step_o  out  1  combinational; generator advances one word at the next edge.
- prng_load_o  out  1  registered; generator loads prng_seed_o at the next edge.
- prng_seed_o  out  WIDTH  registered seed to the generator.

## Operation
- States:
  - WARMUP: prng_step_o=1 every cycle; 16-bit counter decrements. Exit to SERVE on the cycle the counter steps from 1 to 0. If WARMUP==0, go straight to SERVE.
  - SERVE: normal arbitration.
  - LOAD: one cycle with prng_load_o=1, prng_step_o=0, no grants. Then the counter reloads to WARMUP and the block enters WARMUP (or SERVE if WARMUP==0).
- seed_load_i=1 in any state: capture seed_i into prng_seed_o and go to LOAD at the next edge. This has priority over grants in the same cycle, so no grant and no step occur. A reseed during WARMUP restarts warm-up.
- Arbitration in SERVE:
  - Eligible set = req_i & ~gnt_o. The requester currently seeing its grant is masked for that cycle.
  - Pick the first eligible index at or after rr_ptr, wrapping modulo NUM_REQ.
  - When a winner exists:
    - prng_step_o=1 in that cycle.
    - At the next edge: gnt_o = onehot(winner); rnd_o = prng_data_i (the pre-step word); rr_ptr = winner+1 mod NUM_REQ.
  - No eligible request: prng_step_o=0; gnt_o=0; rnd_o and rr_ptr hold.
- Each word is granted exactly once. The generator steps exactly once per grant and once per warm-up cycle, never otherwise.
- Requester protocol: drop req_i in the cycle after gnt_o is seen. A req_i still high one cycle after its gnt_o is treated as a new request.
- req_i is ignored outside SERVE. Pending requests are served once SERVE is entered.

## Timing
- Asynchronous reset drives all of the following to 0 immediately: gnt_o, rnd_o, prng_load_o, prng_seed_o, rr_ptr.
- In the same reset, ready_o=0 and prng_step_o=0.
- After reset: state=WARMUP, counter=WARMUP (SERVE if WARMUP==0).
- Warm-up lasts exactly WARMUP cycles after the first rising edge with rst_ni=1. ready_o rises on the following cycle.
- Grant latency: 1 cycle from an eligible req_i to gnt_o/rnd_o. Throughput: 1 grant per cycle.
- A single requester holding req_i continuously is granted every other cycle.
- A reset mid-operation aborts any in-flight grant; gnt_o goes to 0 asynchronously.
- Reseed: seed_load_i at cycle t leads to prng_load_o=1 and ready_o=0 in cycle t+1. Warm-up runs from t+2, and SERVE resumes at t+2+WARMUP.

## Test plan
- Reset, then warm-up, with WARMUP=8 and all req_i=0:
  - prng_step_o high for exactly 8 cycles after release; ready_o rises at cycle 9.
  - gnt_o stays 0; the reference-model PRNG is 8 words ahead.
- Round-robin fairness, with req_i=4'b1111 held and each requester dropping after its grant:
  - Grant order 0,1,2,3 on consecutive cycles.
  - rnd_o equals reference words W8,W9,W10,W11 with no repeats.
- Wrap-around: rr_ptr=3 with req_i=4'b1001 gives grants to 3 then 0. A later request from 2 alone is granted next cycle.
- Single hog: req_i[1] held high for 10 cycles gives 5 grants to requester 1 on alternating cycles, with 5 distinct words.
- Reseed while busy:
  - seed_load_i=1, seed_i=32'hDEADBEEF while req_i=4'b0010 is pending.
  - No grant that cycle; prng_load_o=1 next cycle with prng_seed_o=32'hDEADBEEF.
  - 8 step cycles follow, then requester 1 receives word 8 of the new sequence.
- Reset mid-grant: drop rst_ni in the same cycle as a gnt_o pulse.
  - gnt_o, rnd_o and ready_o go to 0 immediately.
  - The full 8-cycle warm-up repeats after release.
